crc8_frame_rx: RTL and testbench
================================

CRC8_FRAME_RX -- requirements
Module: crc8_frame_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- SYNC, 8'hA5, start-of-frame byte
- POLY, 8'h07, CRC-8 generator polynomial
- MAX_LEN, 64, largest legal payload length, 1..255
- TIMEOUT, 255, idle cycles tolerated mid-frame, 1..65535
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk, in, 1, single clock, rising edge
- rst, in, 1, synchronous reset, active-high
- in_valid, in, 1, in_byte is valid this cycle; no backpressure
- in_byte, in, 8, received byte
- out_valid, out, 1, payload byte valid
- out_byte, out, 8, payload byte
- out_last, out, 1, marks the final payload byte
- frame_done, out, 1, one-cycle end-of-frame pulse
- frame_ok, out, 1, frame verdict, valid while frame_done=1
- err_code, out, 2, 0 ok, 1 crc, 2 length, 3 timeout; valid while frame_done=1
- err_cnt, out, 16, saturating count of bad frames
- crc_calc, out, 8, running CRC of the current frame

Function
REQ-003 Frame format SHALL be SYNC, LEN, LEN payload bytes, CRC byte; the CRC covers payload only.
REQ-004 CRC SHALL use init 8'h00, MSB-first processing, POLY, no reflection and no final XOR; one byte is folded per accepted cycle.
REQ-005 The FSM SHALL have states HUNT, LEN, PAYLOAD and CHECK; reset enters HUNT.
REQ-006 In HUNT, a byte equal to SYNC SHALL move the FSM to LEN and clear the CRC to 0; other bytes are discarded silently.
REQ-007 In LEN, LEN=0 or LEN>MAX_LEN SHALL give a length error (err_code=2) and return to HUNT; otherwise the FSM latches LEN into a down-counter and moves to PAYLOAD.
REQ-008 In PAYLOAD, each byte SHALL be folded into the CRC and forwarded on out_byte one cycle later with out_valid=1; the last byte has out_last=1, and the FSM then moves to CHECK.
REQ-009 In CHECK, the received byte SHALL be compared with crc_calc: a match gives err_code=0 and frame_ok=1, a mismatch gives err_code=1; either way the FSM returns to HUNT.
REQ-010 frame_done SHALL pulse exactly one cycle after the terminating byte (CRC byte or bad LEN byte); frame_ok and err_code are meaningful only on that cycle and 0 otherwise.
REQ-011 Idle timer: in LEN, PAYLOAD or CHECK, TIMEOUT consecutive cycles with in_valid=0 SHALL end the frame with err_code=3 and return the FSM to HUNT.
REQ-012 After a timeout, the next byte (even SYNC) SHALL be evaluated in HUNT on the following cycle.
REQ-013 Bytes with in_valid=0 SHALL leave the CRC, counter and outputs unchanged, apart from the idle timer.
REQ-014 err_cnt SHALL increment once per frame_done with frame_ok=0 and saturate at 16'hFFFF.
REQ-015 A SYNC-valued byte inside LEN, PAYLOAD or CHECK SHALL be treated as data; there is no resynchronisation mid-frame.
REQ-016 Back-to-back frames SHALL be supported: a SYNC byte in the cycle right after the CRC byte is accepted.

Reset
REQ-017 rst=1 at a clock edge SHALL force state HUNT, with out_valid, out_last, frame_done, frame_ok, err_code, err_cnt, crc_calc, the length counter and the idle timer all 0.
REQ-018 A reset mid-frame SHALL abandon the frame without a frame_done pulse.
REQ-019 out_byte SHALL reset to 8'h00.

Structure
REQ-020 A shared package crc8_pkg SHALL hold the FSM state enum, the err_code constants and a pure function crc8_step(crc, byte, poly).
REQ-021 One sub-module, crc8_byte_step (combinational, one byte per call), SHALL wrap crc8_step; the FSM, counters and output registers live in crc8_frame_rx.

Verification
REQ-022 Send A5 09 "123456789" F4 -> nine out_valid bytes, out_last on '9', then frame_done=1, frame_ok=1, err_code=0.
REQ-023 Send the same frame with CRC byte 00 -> frame_done=1, frame_ok=0, err_code=1, err_cnt=1.
REQ-024 Send A5 00, then A5 41 (MAX_LEN=64) -> two length errors (err_code=2), no out_valid, err_cnt=2.
REQ-025 Send A5 03 11 22 then idle 255 cycles -> frame_done with err_code=3; a following A5 01 00 00 frame passes with frame_ok=1.
REQ-026 Send junk 00 FF, then back-to-back good frames with gaps of in_valid=0 inside them -> both pass, and out_valid never asserts during junk.
REQ-027 Assert rst during PAYLOAD -> no frame_done pulse, all outputs 0 next cycle, and the next good frame passes.

Source files
------------

// File: rtl/crc8_pkg.sv
// crc8_pkg: shared FSM states, error codes and the CRC-8 byte step for the frame receiver
package crc8_pkg;
    typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CHECK} state_t;
    localparam logic [1:0] ERR_OK = 2'd0, ERR_CRC = 2'd1, ERR_LEN = 2'd2, ERR_TIMEOUT = 2'd3;
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data, input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ poly : {c[6:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/crc8_byte_step.sv
// crc8_byte_step: folds one byte into a CRC-8, MSB first, no reflection
module crc8_byte_step
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] nxt
);
    assign nxt = crc8_step(crc, data, POLY);
endmodule

// File: rtl/crc8_frame_rx.sv
// crc8_frame_rx: SYNC/LEN/payload/CRC-8 frame receiver with payload forwarding and error reporting
module crc8_frame_rx
    import crc8_pkg::*;
#(
    parameter logic [7:0] SYNC = 8'hA5,
    parameter logic [7:0] POLY = 8'h07,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic [15:0] err_cnt,
    output logic [7:0]  crc_calc
);
    localparam logic [7:0] MAX_B = 8'(MAX_LEN);
    localparam logic [15:0] TO_B = 16'(TIMEOUT);
    state_t state;
    logic [7:0] cnt;
    logic [15:0] idle;
    logic [7:0] crc_nxt;
    logic timed_out, bad_len, end_frame;
    logic [1:0] end_code;
    crc8_byte_step #(.POLY(POLY)) u_step (.crc(crc_calc), .data(in_byte), .nxt(crc_nxt));
    assign timed_out = state != ST_HUNT && !in_valid && idle == TO_B - 16'd1;
    assign bad_len = in_byte == 8'd0 || in_byte > MAX_B;
    assign end_frame = timed_out || (in_valid && ((state == ST_LEN && bad_len) || state == ST_CHECK));
    assign end_code = timed_out ? ERR_TIMEOUT : state == ST_LEN ? ERR_LEN : in_byte == crc_calc ? ERR_OK : ERR_CRC;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HUNT;
            cnt        <= 8'd0;
            idle       <= 16'd0;
            crc_calc   <= 8'd0;
            out_valid  <= 1'b0;
            out_byte   <= 8'd0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= ERR_OK;
            err_cnt    <= 16'd0;
        end else begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= end_frame;
            frame_ok   <= end_frame && end_code == ERR_OK;
            err_code   <= end_frame ? end_code : ERR_OK;
            if (end_frame && end_code != ERR_OK && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            // idle timer only runs inside a frame and restarts on every accepted byte
            idle <= (state == ST_HUNT || in_valid || timed_out) ? 16'd0 : idle + 16'd1;
            if (end_frame) state <= ST_HUNT;
            else if (in_valid) begin
                case (state)
                    ST_HUNT: if (in_byte == SYNC) begin
                        state    <= ST_LEN;
                        crc_calc <= 8'd0;
                    end
                    ST_LEN: begin
                        cnt   <= in_byte;
                        state <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        crc_calc  <= crc_nxt;
                        out_valid <= 1'b1;
                        out_byte  <= in_byte;
                        out_last  <= cnt == 8'd1;
                        cnt       <= cnt - 8'd1;
                        if (cnt == 8'd1) state <= ST_CHECK;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_crc8_frame_rx.sv
// tb_crc8_frame_rx: directed frame sequences with hand-computed CRC-8 verdicts
module tb_crc8_frame_rx;
    logic clk = 1'b0, rst, in_valid;
    logic [7:0] in_byte;
    logic out_valid, out_last, frame_done, frame_ok;
    logic [7:0] out_byte, crc_calc;
    logic [1:0] err_code;
    logic [15:0] err_cnt;
    int vectors = 0, miscompares = 0;
    logic [15:0] exp_err = 16'd0;
    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc8_frame_rx #(.SYNC(8'hA5), .POLY(8'h07), .MAX_LEN(64), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code),
        .err_cnt(err_cnt), .crc_calc(crc_calc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_quiet(input string tag, input logic [7:0] b);
        send(b);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " frame_done"}, frame_done, 0);
    endtask

    task automatic send_pay(input logic [7:0] b, input logic last);
        send(b);
        chk("pay out_valid", out_valid, 1);
        chk("pay out_byte", out_byte, b);
        chk("pay out_last", out_last, last);
        chk("pay frame_done", frame_done, 0);
    endtask

    task automatic send_end(input logic [7:0] b, input logic ok, input logic [1:0] code);
        send(b);
        if (!ok) exp_err++;
        chk("end frame_done", frame_done, 1);
        chk("end frame_ok", frame_ok, ok);
        chk("end err_code", err_code, code);
        chk("end err_cnt", err_cnt, exp_err);
        chk("end out_valid", out_valid, 0);
        gap(1);
        chk("done pulse width", frame_done, 0);
        chk("ok idle", frame_ok, 0);
        chk("code idle", err_code, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_byte", out_byte, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("rst crc_calc", crc_calc, 0);
        rst = 1'b0;
        gap(1);

        send_quiet("sync", 8'hA5);
        send_quiet("len", 8'h09);
        for (int i = 0; i < 9; i++) send_pay(msg[i], i == 8);
        chk("crc 123456789", crc_calc, 16'h00F4);
        send_end(8'hF4, 1, 2'd0);

        send_quiet("sync", 8'hA5);
        send_quiet("len", 8'h09);
        for (int i = 0; i < 9; i++) send_pay(msg[i], i == 8);
        send_end(8'h00, 0, 2'd1);

        send_quiet("sync", 8'hA5);
        send_end(8'h00, 0, 2'd2);
        send_quiet("sync", 8'hA5);
        send_end(8'h41, 0, 2'd2);

        send_quiet("sync", 8'hA5);
        send_quiet("len max", 8'h40);
        for (int i = 0; i < 64; i++) send_pay(8'h00, i == 63);
        send_end(8'h00, 1, 2'd0);

        send_quiet("sync", 8'hA5);
        send_quiet("len", 8'h03);
        send_pay(8'h11, 0);
        send_pay(8'h22, 0);
        gap(254);
        chk("timeout early", frame_done, 0);
        gap(1);
        exp_err++;
        chk("timeout done", frame_done, 1);
        chk("timeout ok", frame_ok, 0);
        chk("timeout code", err_code, 3);
        chk("timeout err_cnt", err_cnt, exp_err);
        send_quiet("sync", 8'hA5);
        send_quiet("len", 8'h01);
        send_pay(8'h00, 1);
        send_end(8'h00, 1, 2'd0);

        send_quiet("junk", 8'h00);
        send_quiet("junk", 8'hFF);
        send_quiet("sync", 8'hA5);
        gap(3);
        send_quiet("len", 8'h01);
        gap(2);
        send_pay(8'hA5, 1);
        gap(4);
        chk("gap out_valid", out_valid, 0);
        chk("gap out_byte hold", out_byte, 16'h00A5);
        chk("gap crc hold", crc_calc, 16'h0072);
        send(8'h72);
        exp_err = exp_err;
        chk("b2b1 done", frame_done, 1);
        chk("b2b1 ok", frame_ok, 1);
        send_quiet("sync b2b", 8'hA5);
        chk("b2b crc cleared", crc_calc, 0);
        send_quiet("len", 8'h01);
        gap(2);
        send_pay(8'h01, 1);
        gap(1);
        send_end(8'h07, 1, 2'd0);

        send_quiet("sync", 8'hA5);
        send_quiet("len", 8'h05);
        send_pay(8'h11, 0);
        send_pay(8'h22, 0);
        rst = 1'b1;
        send(8'h33);
        rst = 1'b0;
        exp_err = 16'd0;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_byte", out_byte, 0);
        chk("midrst out_last", out_last, 0);
        chk("midrst frame_done", frame_done, 0);
        chk("midrst err_code", err_code, 0);
        chk("midrst err_cnt", err_cnt, 0);
        chk("midrst crc_calc", crc_calc, 0);
        send_quiet("post rst junk", 8'h44);
        send_quiet("post rst junk", 8'h55);
        send_quiet("sync", 8'hA5);
        send_quiet("len", 8'h01);
        send_pay(8'h01, 1);
        send_end(8'h07, 1, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
